// File: rtl/inst_loader_pkg.sv
// Shared constants and FSM encoding for the instruction memory loader.
// Optional INST_LOADER_CHECKSUM_EN adds the CHECK state used by the trailing checksum byte.
package inst_loader_pkg;

    localparam int          BYTES_PER_WORD = 4;
    localparam int          ADDR_STEP      = 4;
    localparam logic [31:0] HALT_INSTR     = 32'hFC00_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
`ifdef INST_LOADER_CHECKSUM_EN
        ST_ERROR = 3'd4,
        ST_CHECK = 3'd5
`else
        ST_ERROR = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/byte_to_word_packer.sv
// Shifts accepted bytes MSB-first into a word and flags the byte that completes it.
module byte_to_word_packer
    import inst_loader_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 accept,
    input  logic [7:0]           data_in,
    output logic [WORD_SIZE-1:0] word,
    output logic                 word_valid
);

    logic [1:0] byte_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (accept) begin
            word     <= {word[WORD_SIZE-9:0], data_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // High during the cycle whose accepted byte is the last of the word.
    assign word_valid = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_mem_loader.sv
// Streams program bytes into instruction memory words until HALT or overflow.
// Define INST_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after HALT.
module inst_mem_loader
    import inst_loader_pkg::*;
#(
    parameter int PC_SIZE   = 32,
    parameter int WORD_SIZE = 32,
    parameter int MEM_WORDS = 64
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_start_load,
    input  logic                             i_byte_valid,
    input  logic [7:0]                       i_byte,
    output logic                             o_byte_ready,
    output logic                             o_mem_wr_en,
    output logic [PC_SIZE-1:0]               o_mem_addr,
    output logic [WORD_SIZE-1:0]             o_mem_wr_data,
    output logic [$clog2(MEM_WORDS+1)-1:0]   o_word_count,
    output logic                             o_load_done,
    output logic                             o_load_error
);

    localparam int CW = $clog2(MEM_WORDS + 1);

    state_t               state, state_next;
    logic [PC_SIZE-1:0]   addr;
    logic [CW-1:0]        word_count;
    logic [WORD_SIZE-1:0] word;
    logic                 word_valid;
    logic                 ready;
    logic                 pack_accept;
    logic                 clear;
    logic                 wr_en;
    logic                 load_done;
    logic                 load_error;

`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    assign ready = (state == ST_RECV) || (state == ST_CHECK);
`else
    assign ready = (state == ST_RECV);
`endif

    // Only program bytes go to the packer; the checksum byte is consumed by the FSM.
    assign pack_accept = i_byte_valid && (state == ST_RECV);

    byte_to_word_packer #(
        .WORD_SIZE (WORD_SIZE)
    ) u_packer (
        .clk        (i_clk),
        .rst_n      (i_reset),
        .clear      (clear),
        .accept     (pack_accept),
        .data_in    (i_byte),
        .word       (word),
        .word_valid (word_valid)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        load_done  = 1'b0;
        load_error = 1'b0;
        clear      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start_load) begin
                    clear      = 1'b1;
                    state_next = ST_RECV;
                end
            end
            ST_RECV: begin
                if (word_valid) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                wr_en = 1'b1;
                if (word == HALT_INSTR)
`ifdef INST_LOADER_CHECKSUM_EN
                    state_next = ST_CHECK;
`else
                    state_next = ST_DONE;
`endif
                else if (word_count == CW'(MEM_WORDS - 1))
                    state_next = ST_ERROR;
                else
                    state_next = ST_RECV;
            end
            ST_DONE, ST_ERROR: begin
                load_done  = (state == ST_DONE);
                load_error = (state == ST_ERROR);
                if (i_start_load) begin
                    clear      = 1'b1;
                    state_next = ST_RECV;
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (i_byte_valid) state_next = (i_byte == csum) ? ST_DONE : ST_ERROR;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: reset is synchronous; it is just the highest-priority branch of the clocked block.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state      <= ST_IDLE;
            addr       <= '0;
            word_count <= '0;
        end else begin
            state <= state_next;
            if (clear) begin
                addr       <= '0;
                word_count <= '0;
            end else if (wr_en) begin
                addr       <= addr + PC_SIZE'(ADDR_STEP);
                word_count <= word_count + CW'(1);
            end
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset || clear) csum <= '0;
        else if (pack_accept)  csum <= csum ^ i_byte;
    end
`endif

    assign o_byte_ready  = ready;
    assign o_mem_wr_en   = wr_en;
    assign o_mem_addr    = addr;
    assign o_mem_wr_data = wr_en ? word : '0;
    assign o_word_count  = word_count;
    assign o_load_done   = load_done;
    assign o_load_error  = load_error;

endmodule
